// File: rtl/uart_frame_checker.sv
// rtl/uart_frame_checker.sv - validates SYNC/LEN/payload/CHK frames from uart_rx
// Buffers the payload and replays it to the parser only once LEN and checksum are confirmed good.
module uart_frame_checker #(
  parameter int         MAX_PAYLOAD    = 128,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 5_000_000,
  parameter int         REPLAY_GAP     = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] byte_in,
  output logic       valid_out,
  output logic [7:0] byte_out,
  output logic       frame_ok,
  output logic       frame_err,
  output logic [2:0] err_code,
  output logic       busy,
  output logic [7:0] frame_len
);

  localparam int IW = $clog2(MAX_PAYLOAD + 1);
  localparam int AW = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int GW = (REPLAY_GAP > 1) ? $clog2(REPLAY_GAP) : 1;

  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_RELOAD = GW'(REPLAY_GAP - 1);

  localparam logic [2:0] ERR_BAD_LEN      = 3'd1;
  localparam logic [2:0] ERR_BAD_CHECKSUM = 3'd2;
  localparam logic [2:0] ERR_TIMEOUT      = 3'd3;
  localparam logic [2:0] ERR_OVERRUN      = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN,
    S_PAYLOAD,
    S_CHK,
    S_REPLAY
  } state_t;

  state_t          state, state_nx;
  logic [7:0]      acc, acc_nx;
  logic [IW-1:0]   len_q, len_nx;
  logic [IW-1:0]   wr_idx, wr_nx;
  logic [IW-1:0]   rd_idx, rd_nx;
  logic [GW-1:0]   gap_cnt, gap_nx;
  logic [TW-1:0]   timer, timer_nx;
  logic            emit;
  logic            frame_ok_nx, frame_err_nx;
  logic [2:0]      err_code_nx;
  logic [7:0]      frame_len_nx;
  logic [IW-1:0]   wr_inc;
  logic [7:0]      chk_sum;

  logic [7:0]      buf_mem [MAX_PAYLOAD];

  assign wr_inc  = wr_idx + IW'(1);
  assign chk_sum = acc + byte_in;
  assign busy    = (state != S_IDLE);

  always_comb begin
    state_nx     = state;
    acc_nx       = acc;
    len_nx       = len_q;
    wr_nx        = wr_idx;
    rd_nx        = rd_idx;
    gap_nx       = gap_cnt;
    timer_nx     = '0;
    emit         = 1'b0;
    frame_ok_nx  = 1'b0;
    frame_err_nx = 1'b0;
    err_code_nx  = err_code;
    frame_len_nx = frame_len;
    unique case (state)
      S_IDLE: begin
        if (valid_in && byte_in == SYNC_BYTE) state_nx = S_LEN;
      end
      S_LEN, S_PAYLOAD, S_CHK: begin
        // An arriving byte always beats timer expiry in the same cycle.
        if (!valid_in) begin
          if (timer == TIMER_LAST) begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_TIMEOUT;
            state_nx     = S_IDLE;
          end else begin
            timer_nx = timer + TW'(1);
          end
        end else if (state == S_LEN) begin
          if (byte_in == 8'd0 || byte_in > 8'(MAX_PAYLOAD)) begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_BAD_LEN;
            state_nx     = S_IDLE;
          end else begin
            len_nx   = IW'(byte_in);
            acc_nx   = byte_in;
            wr_nx    = '0;
            state_nx = S_PAYLOAD;
          end
        end else if (state == S_PAYLOAD) begin
          acc_nx = acc + byte_in;
          wr_nx  = wr_inc;
          if (wr_inc == len_q) state_nx = S_CHK;
        end else begin
          if (chk_sum == 8'd0) begin
            frame_ok_nx  = 1'b1;
            frame_len_nx = 8'(len_q);
            rd_nx        = '0;
            gap_nx       = '0;
            state_nx     = S_REPLAY;
          end else begin
            frame_err_nx = 1'b1;
            err_code_nx  = ERR_BAD_CHECKSUM;
            state_nx     = S_IDLE;
          end
        end
      end
      S_REPLAY: begin
        if (valid_in) begin
          frame_err_nx = 1'b1;
          err_code_nx  = ERR_OVERRUN;
        end
        if (valid_out && rd_idx == len_q) begin
          state_nx = S_IDLE;
        end else if (gap_cnt == '0 && rd_idx != len_q) begin
          emit   = 1'b1;
          rd_nx  = rd_idx + IW'(1);
          gap_nx = GAP_RELOAD;
        end else if (gap_cnt != '0) begin
          gap_nx = gap_cnt - GW'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      acc       <= '0;
      len_q     <= '0;
      wr_idx    <= '0;
      rd_idx    <= '0;
      gap_cnt   <= '0;
      timer     <= '0;
      valid_out <= 1'b0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      err_code  <= '0;
      frame_len <= '0;
    end else begin
      state     <= state_nx;
      acc       <= acc_nx;
      len_q     <= len_nx;
      wr_idx    <= wr_nx;
      rd_idx    <= rd_nx;
      gap_cnt   <= gap_nx;
      timer     <= timer_nx;
      valid_out <= emit;
      frame_ok  <= frame_ok_nx;
      frame_err <= frame_err_nx;
      err_code  <= err_code_nx;
      frame_len <= frame_len_nx;
    end
  end

  // Writes happen only in PAYLOAD and reads only in REPLAY, so one port suffices.
  always_ff @(posedge clk) begin
    if (!rst && state == S_PAYLOAD && valid_in) buf_mem[wr_idx[AW-1:0]] <= byte_in;
  end

  always_ff @(posedge clk) begin
    if (rst)       byte_out <= '0;
    else if (emit) byte_out <= buf_mem[rd_idx[AW-1:0]];
  end

endmodule

// File: tb/tb_uart_frame_checker.sv
// tb/tb_uart_frame_checker.sv - randomized self-checking bench for uart_frame_checker
// A frame-level model predicts ok/err/replay events and their cycle stamps from the sent byte stream.
module tb_uart_frame_checker;

  localparam int MAXP = 128;
  localparam int TMO  = 2000;
  localparam int GAP  = 4;

  logic       clk;
  logic       rst;
  logic       valid_in;
  logic [7:0] byte_in;
  logic       valid_out;
  logic [7:0] byte_out;
  logic       frame_ok;
  logic       frame_err;
  logic [2:0] err_code;
  logic       busy;
  logic [7:0] frame_len;

  uart_frame_checker #(
    .MAX_PAYLOAD(MAXP),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TMO),
    .REPLAY_GAP(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .valid_in(valid_in),
    .byte_in(byte_in),
    .valid_out(valid_out),
    .byte_out(byte_out),
    .frame_ok(frame_ok),
    .frame_err(frame_err),
    .err_code(err_code),
    .busy(busy),
    .frame_len(frame_len)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  int sent_b[$], sent_c[$];
  int obs_ok[$], obs_vo_c[$], obs_vo_b[$], obs_err_c[$], obs_err_k[$], obs_fall[$];
  int exp_ok[$], exp_vo_c[$], exp_vo_b[$], exp_err_c[$], exp_err_k[$], exp_fall[$];
  int exp_frame_len = 0;
  int exp_last_code = 0;
  logic [7:0] fr[$];
  bit prev_busy = 1'b0;

  always @(negedge clk) begin
    if (valid_out === 1'b1) begin
      obs_vo_c.push_back(cyc);
      obs_vo_b.push_back(int'(byte_out));
    end
    if (frame_ok === 1'b1) obs_ok.push_back(cyc);
    if (frame_err === 1'b1) begin
      obs_err_c.push_back(cyc);
      obs_err_k.push_back(int'(err_code));
    end
    if (prev_busy && busy === 1'b0) obs_fall.push_back(cyc);
    prev_busy <= (busy === 1'b1);
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clear_all();
    sent_b.delete(); sent_c.delete();
    obs_ok.delete(); obs_vo_c.delete(); obs_vo_b.delete();
    obs_err_c.delete(); obs_err_k.delete(); obs_fall.delete();
    exp_ok.delete(); exp_vo_c.delete(); exp_vo_b.delete();
    exp_err_c.delete(); exp_err_k.delete(); exp_fall.delete();
  endtask

  // Called at a negedge; the byte is taken by the following posedge.
  task automatic send_byte(input logic [7:0] b, input int gap, input bit rec);
    valid_in = 1'b1;
    byte_in  = b;
    if (rec) begin
      sent_b.push_back(int'(b));
      sent_c.push_back(cyc + 1);
    end
    @(negedge clk);
    valid_in = 1'b0;
    byte_in  = 8'h00;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_q(input int gap, input bit rnd);
    int g;
    for (int i = 0; i < fr.size(); i++) begin
      if (i == fr.size() - 1) g = 1;
      else if (rnd)           g = int'($urandom_range(1, 6));
      else                    g = gap;
      send_byte(fr[i], g, 1'b1);
    end
    fr.delete();
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (busy && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", int'(busy), 0);
    repeat (4) @(negedge clk);
  endtask

  task automatic expect_err(input int c, input int code, input bit ends_frame);
    exp_err_c.push_back(c);
    exp_err_k.push_back(code);
    if (ends_frame) exp_fall.push_back(c);
    exp_last_code = code;
  endtask

  // Frame-level reading of the sent stream: find SYNC, judge LEN, sum, replay schedule.
  task automatic run_model();
    int i, n, len, sum, cc;
    i = 0;
    n = sent_b.size();
    while (i < n) begin
      if (sent_b[i] != 8'hA5) begin
        i++;
        continue;
      end
      if (i + 1 >= n) begin
        expect_err(sent_c[n-1] + TMO, 3, 1'b1);
        break;
      end
      len = sent_b[i+1];
      if (len == 0 || len > MAXP) begin
        expect_err(sent_c[i+1], 1, 1'b1);
        i += 2;
        continue;
      end
      if (i + 2 + len >= n) begin
        expect_err(sent_c[n-1] + TMO, 3, 1'b1);
        break;
      end
      sum = len + sent_b[i+2+len];
      for (int k = 0; k < len; k++) sum += sent_b[i+2+k];
      cc = sent_c[i+2+len];
      if (sum % 256 == 0) begin
        exp_ok.push_back(cc);
        for (int k = 0; k < len; k++) begin
          exp_vo_c.push_back(cc + 1 + k * GAP);
          exp_vo_b.push_back(sent_b[i+2+k]);
        end
        exp_fall.push_back(cc + 2 + (len - 1) * GAP);
        exp_frame_len = len;
      end else begin
        expect_err(cc, 2, 1'b1);
      end
      i += 3 + len;
    end
  endtask

  task automatic compare_events(input string tag);
    check({tag, " ok_count"}, obs_ok.size(), exp_ok.size());
    for (int i = 0; i < obs_ok.size() && i < exp_ok.size(); i++)
      check({tag, " ok_cycle"}, obs_ok[i], exp_ok[i]);
    check({tag, " out_count"}, obs_vo_c.size(), exp_vo_c.size());
    for (int i = 0; i < obs_vo_c.size() && i < exp_vo_c.size(); i++) begin
      check({tag, " out_cycle"}, obs_vo_c[i], exp_vo_c[i]);
      check({tag, " out_byte"}, obs_vo_b[i], exp_vo_b[i]);
    end
    check({tag, " err_count"}, obs_err_c.size(), exp_err_c.size());
    for (int i = 0; i < obs_err_c.size() && i < exp_err_c.size(); i++) begin
      check({tag, " err_cycle"}, obs_err_c[i], exp_err_c[i]);
      check({tag, " err_code"}, obs_err_k[i], exp_err_k[i]);
    end
    check({tag, " busy_fall_count"}, obs_fall.size(), exp_fall.size());
    for (int i = 0; i < obs_fall.size() && i < exp_fall.size(); i++)
      check({tag, " busy_fall_cycle"}, obs_fall[i], exp_fall[i]);
    check({tag, " frame_len"}, int'(frame_len), exp_frame_len);
    check({tag, " err_code_hold"}, int'(err_code), exp_last_code);
    clear_all();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " valid_out"}, int'(valid_out), 0);
    check({tag, " byte_out"}, int'(byte_out), 0);
    check({tag, " frame_ok"}, int'(frame_ok), 0);
    check({tag, " frame_err"}, int'(frame_err), 0);
    check({tag, " err_code"}, int'(err_code), 0);
    check({tag, " busy"}, int'(busy), 0);
    check({tag, " frame_len"}, int'(frame_len), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int kind, len, g, sum, ov, d;
    logic [7:0] b, chk;

    rst = 1'b1; valid_in = 1'b0; byte_in = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_all();

    fr = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    send_q(1000, 1'b0);
    wait_idle(TMO + MAXP * GAP + 100);
    run_model();
    compare_events("good");

    fr = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF6};
    send_q(7, 1'b0);
    wait_idle(TMO + 100);
    run_model();
    compare_events("bad_chk");

    fr = '{8'hA5, 8'h00, 8'hA5, 8'h81, 8'hA5, 8'h80};
    for (int k = 0; k < MAXP; k++) fr.push_back(8'h00);
    fr.push_back(8'h80);
    send_q(2, 1'b0);
    wait_idle(TMO + MAXP * GAP + 100);
    run_model();
    compare_events("len_bounds");

    fr = '{8'h11, 8'h22, 8'hA5, 8'h02, 8'h05};
    send_q(5, 1'b0);
    wait_idle(TMO + 100);
    run_model();
    compare_events("timeout");

    fr = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF7};
    send_q(3, 1'b0);
    d = int'($urandom_range(0, 7));
    repeat (d) @(negedge clk);
    ov = cyc + 1;
    send_byte(8'h33, 1, 1'b0);
    wait_idle(TMO + 100);
    run_model();
    expect_err(ov, 4, 1'b0);
    compare_events("overrun");

    fr = '{8'hA5, 8'h03, 8'h01};
    send_q(3, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check_all_zero("reset_mid_frame");
    rst = 1'b0;
    repeat (2) @(negedge clk);
    clear_all();
    exp_frame_len = 0;
    exp_last_code = 0;
    repeat (50) @(negedge clk);
    fr = '{8'hA5, 8'h02, 8'h10, 8'hA5, 8'h49};
    send_q(4, 1'b0);
    wait_idle(TMO + 100);
    run_model();
    compare_events("after_reset");

    for (int f = 0; f < 25; f++) begin
      kind = int'($urandom_range(0, 9));
      g = int'($urandom_range(0, 2));
      for (int k = 0; k < g; k++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        fr.push_back(b);
      end
      fr.push_back(8'hA5);
      if (kind == 0) begin
        fr.push_back(8'h00);
      end else if (kind == 1) begin
        fr.push_back(8'($urandom_range(MAXP + 1, 255)));
      end else begin
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MAXP)) : int'($urandom_range(1, 8));
        fr.push_back(8'(len));
        sum = len;
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          fr.push_back(b);
          sum += int'(b);
        end
        chk = 8'(256 - (sum % 256));
        if (kind <= 3) chk = chk ^ 8'($urandom_range(1, 255));
        fr.push_back(chk);
      end
      send_q(0, 1'b1);
      wait_idle(TMO + MAXP * GAP + 100);
      run_model();
      compare_events("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
